// File: rtl/knn_local_pkg.sv
// Shared widths and request types for the kNN local search-point buffer.
package knn_local_pkg;
    localparam int DATA_W = 256;
    localparam int DEPTH  = 2048;
    localparam int ADDR_W = 11;
    localparam int TAG_W  = 4;

    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
    } rd_req_t;
endpackage

// File: rtl/knn_rd_lat_pipe.sv
// Valid/tag shift register that mirrors the memory read latency and
// reports whether any read is still travelling through it.
module knn_rd_lat_pipe #(
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic             inflight
);
    logic [STAGES-1:0] valid_reg;
    logic [TAG_W-1:0]  tag_reg [STAGES];

    // Tags enter as zero with empty slots so the returned tag is already qualified.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
            for (int i = 0; i < STAGES; i++) begin
                tag_reg[i] <= '0;
            end
        end else begin
            valid_reg[0] <= in_valid;
            tag_reg[0]   <= in_valid ? in_tag : '0;
            for (int i = 1; i < STAGES; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                tag_reg[i]   <= tag_reg[i-1];
            end
        end
    end

    assign out_valid = valid_reg[STAGES-1];
    assign out_tag   = tag_reg[STAGES-1];
    assign inflight  = |valid_reg;
endmodule

// File: rtl/knn_local_sp_arbiter.sv
// Shares one single-port URAM between a sequential tile fill stream and
// random-address reads, blocking reads of words not yet written.
module knn_local_sp_arbiter
    import knn_local_pkg::*;
#(
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [TAG_W-1:0]  rd_tag,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [ADDR_W:0]   fill_count,
    output logic              full,
    output logic              rd_inflight,
    output logic [ADDR_W-1:0] mem_address0,
    output logic              mem_ce0,
    output logic              mem_we0,
    output logic [DATA_W-1:0] mem_d0,
    input  logic [DATA_W-1:0] mem_q0
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W:0]   fill_ptr_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [ADDR_W-1:0] mem_address0_reg;
    logic              mem_ce0_reg;
    logic              mem_we0_reg;
    word_t             mem_d0_reg;
    rd_req_t           rd_req;
    logic              full_int;
    logic              rd_elig;
    logic              wr_elig;
    logic              rd_grant;
    logic              wr_grant;
    logic              pipe_tag_unused;

    assign rd_req   = '{addr: rd_addr, tag: rd_tag};
    assign full_int = (fill_ptr_reg == FULL_CNT);
    // Only words already written in this tile may be read back.
    assign rd_elig  = rd_valid && ({1'b0, rd_req.addr} < fill_ptr_reg);
    assign wr_elig  = wr_valid && !full_int;

    always_comb begin
        rd_grant = 1'b0;
        wr_grant = 1'b0;
        if (!reset && !clear) begin
            if (rd_elig && (!wr_elig || wait_cnt_reg >= WAIT_MAX)) begin
                rd_grant = 1'b1;
            end else if (wr_elig) begin
                wr_grant = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_ptr_reg     <= '0;
            wait_cnt_reg     <= '0;
            mem_address0_reg <= '0;
            mem_ce0_reg      <= 1'b0;
            mem_we0_reg      <= 1'b0;
            mem_d0_reg       <= '0;
        end else begin
            mem_ce0_reg <= wr_grant || rd_grant;
            mem_we0_reg <= wr_grant;
            if (wr_grant) begin
                mem_address0_reg <= fill_ptr_reg[ADDR_W-1:0];
                mem_d0_reg       <= wr_data;
            end else if (rd_grant) begin
                mem_address0_reg <= rd_req.addr;
            end

            if (clear) begin
                fill_ptr_reg <= '0;
                wait_cnt_reg <= '0;
            end else begin
                if (wr_grant) begin
                    fill_ptr_reg <= fill_ptr_reg + 1'b1;
                end
                if (rd_grant) begin
                    wait_cnt_reg <= '0;
                end else if (rd_elig && wait_cnt_reg < WAIT_MAX) begin
                    wait_cnt_reg <= wait_cnt_reg + 1'b1;
                end
            end
        end
    end

    knn_rd_lat_pipe #(
        .STAGES (RD_LAT + 1),
        .TAG_W  (TAG_W)
    ) u_lat_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_grant),
        .in_tag    (rd_req.tag),
        .out_valid (rsp_valid),
        .out_tag   (rsp_tag),
        .inflight  (rd_inflight)
    );

    assign pipe_tag_unused = 1'b0;
    assign rsp_data     = rsp_valid ? mem_q0 : '0;
    assign wr_ready     = wr_grant;
    assign rd_ready     = rd_grant;
    assign fill_count   = fill_ptr_reg;
    assign full         = full_int;
    assign mem_address0 = mem_address0_reg;
    assign mem_ce0      = mem_ce0_reg;
    assign mem_we0      = mem_we0_reg;
    assign mem_d0       = mem_d0_reg;
endmodule

// File: tb/tb_knn_local_sp_arbiter.sv
// Randomised bench for the local buffer arbiter with a queue scoreboard
// and a behavioural model of fill order, hazard guard and starvation rule.
module tb_knn_local_sp_arbiter;
    import knn_local_pkg::*;

    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [TAG_W-1:0]  rd_tag;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [TAG_W-1:0]  rsp_tag;
    logic [ADDR_W:0]   fill_count;
    logic              full;
    logic              rd_inflight;
    logic [ADDR_W-1:0] mem_address0;
    logic              mem_ce0;
    logic              mem_we0;
    logic [DATA_W-1:0] mem_d0;
    logic [DATA_W-1:0] mem_q0;

    knn_local_sp_arbiter #(.RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_addr      (rd_addr),
        .rd_tag       (rd_tag),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_tag      (rsp_tag),
        .fill_count   (fill_count),
        .full         (full),
        .rd_inflight  (rd_inflight),
        .mem_address0 (mem_address0),
        .mem_ce0      (mem_ce0),
        .mem_we0      (mem_we0),
        .mem_d0       (mem_d0),
        .mem_q0       (mem_q0)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    // Single-port memory with a two-cycle registered read.
    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] q_s1;
    always @(posedge clk) begin
        if (mem_ce0) begin
            if (mem_we0) ram[mem_address0] <= mem_d0;
            else         q_s1 <= ram[mem_address0];
        end
        mem_q0 <= q_s1;
    end

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        int                due;
    } rsp_t;
    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } op_t;

    rsp_t rsp_q[$];
    op_t  op_q[$];

    logic [DATA_W-1:0] model_mem [DEPTH];
    int model_fill = 0;
    int model_wait = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // One clock cycle of stimulus, entered and left at a falling edge.
    task automatic step(input logic wv, input logic [DATA_W-1:0] wd, input logic rv,
                        input logic [ADDR_W-1:0] ra, input logic [TAG_W-1:0] rt, input logic clr);
        logic e_rd, e_wr, g_rd, g_wr;
        wr_valid = wv; wr_data = wd; rd_valid = rv; rd_addr = ra; rd_tag = rt; clear = clr;
        #1;
        e_rd = rv && (int'(ra) < model_fill);
        e_wr = wv && (model_fill < DEPTH);
        g_rd = !clr && e_rd && (!e_wr || model_wait >= MAX_WAIT);
        g_wr = !clr && e_wr && !g_rd;
        chk("wr_ready", wr_ready, g_wr);
        chk("rd_ready", rd_ready, g_rd);
        chk("fill_count", fill_count, model_fill);
        chk("full", full, model_fill == DEPTH);
        if (g_wr) begin
            op_q.push_back('{1'b1, ADDR_W'(model_fill), wd});
            model_mem[model_fill] = wd;
        end
        if (g_rd) begin
            op_q.push_back('{1'b0, ra, '0});
            rsp_q.push_back('{rt, model_mem[ra], cyc + 1 + RD_LAT});
        end
        if (clr) begin
            model_fill = 0;
            model_wait = 0;
        end else begin
            if (g_wr) model_fill++;
            if (g_rd) model_wait = 0;
            else if (e_rd && model_wait < MAX_WAIT) model_wait++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic check_zero(input string ctx);
        chk({ctx, "_wr_ready"}, wr_ready, '0);
        chk({ctx, "_rd_ready"}, rd_ready, '0);
        chk({ctx, "_rsp_valid"}, rsp_valid, '0);
        chk({ctx, "_rsp_data"}, rsp_data, '0);
        chk({ctx, "_rsp_tag"}, rsp_tag, '0);
        chk({ctx, "_fill_count"}, fill_count, '0);
        chk({ctx, "_full"}, full, '0);
        chk({ctx, "_rd_inflight"}, rd_inflight, '0);
        chk({ctx, "_mem_address0"}, mem_address0, '0);
        chk({ctx, "_mem_ce0"}, mem_ce0, '0);
        chk({ctx, "_mem_we0"}, mem_we0, '0);
        chk({ctx, "_mem_d0"}, mem_d0, '0);
    endtask

    // Monitor: memory port operations and tagged responses against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            chk("rd_inflight", rd_inflight, rsp_q.size() > 0);
            chk("mem_op_present", mem_ce0, op_q.size() > 0);
            if (mem_ce0 && op_q.size() > 0) begin
                op_t op;
                op = op_q.pop_front();
                chk("mem_we0", mem_we0, op.we);
                chk("mem_address0", mem_address0, op.addr);
                if (op.we) chk("mem_d0", mem_d0, op.data);
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 1'b1, 1'b0);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("rsp_tag", rsp_tag, r.tag);
                    chk("rsp_data", rsp_data, r.data);
                    chk("rsp_cycle", cyc, r.due);
                    $display("rsp tag=%0d data[31:0]=%h cycle=%0d", rsp_tag, rsp_data[31:0], cyc);
                end
            end else begin
                chk("rsp_data_idle", rsp_data, '0);
                chk("rsp_tag_idle", rsp_tag, '0);
                if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                    chk("rsp_missing", 1'b0, 1'b1);
                    void'(rsp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int hi;
        int guard;
        reset = 1'b1; clear = 1'b0; wr_valid = 1'b0; wr_data = '0;
        rd_valid = 1'b0; rd_addr = '0; rd_tag = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        // Fill four words, then read three back in order.
        for (int i = 0; i < 4; i++) step(1'b1, DATA_W'(32'hA0 + i), 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, ADDR_W'(i), TAG_W'(i + 1), 1'b0);
        idle(4);

        // Read of an unwritten address stays blocked until it is covered.
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 11'd5, 4'd9, 1'b0);
        step(1'b1, DATA_W'(32'hA4), 1'b1, 11'd5, 4'd9, 1'b0);
        step(1'b1, DATA_W'(32'hA5), 1'b1, 11'd5, 4'd9, 1'b0);
        step(1'b0, '0, 1'b1, 11'd5, 4'd9, 1'b0);
        idle(4);

        // Continuous writes against an eligible read: read forced through.
        for (int i = 0; i < 14; i++) step(1'b1, rand_word(), 1'b1, 11'd0, 4'd7, 1'b0);
        idle(4);

        // Random mix with occasional clears.
        for (int i = 0; i < 400; i++) begin
            hi = (model_fill + 2 > DEPTH - 1) ? DEPTH - 1 : model_fill + 2;
            step(1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 1)),
                 ADDR_W'($urandom_range(0, hi)), TAG_W'($urandom), 1'($urandom_range(0, 99) == 0));
        end
        idle(4);

        // Reset while three reads are in flight.
        for (int i = 0; i < 3; i++) step(1'b1, rand_word(), 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, ADDR_W'(i), TAG_W'(i + 4), 1'b0);
        reset = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1;
        #1;
        check_zero("midreset");
        rsp_q.delete(); op_q.delete();
        model_fill = 0; model_wait = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(6);

        // Fill the whole buffer with sparse reads interleaved.
        guard = 0;
        while (model_fill < DEPTH && guard < 4000) begin
            hi = (model_fill > 0) ? model_fill - 1 : 0;
            step(1'b1, rand_word(), 1'($urandom_range(0, 7) == 0),
                 ADDR_W'($urandom_range(0, hi)), TAG_W'($urandom), 1'b0);
            guard++;
        end
        chk("fill_reached_full", model_fill, DEPTH);
        step(1'b1, rand_word(), 1'b0, '0, '0, 1'b0);
        step(1'b1, rand_word(), 1'b1, 11'd2047, 4'd11, 1'b0);
        step(1'b1, rand_word(), 1'b1, 11'd0, 4'd12, 1'b1);
        step(1'b1, rand_word(), 1'b1, 11'd0, 4'd13, 1'b0);
        idle(10);
        chk("drain_rsp", rsp_q.size(), 0);
        chk("drain_op", op_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
